// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer: mode encoding, default sizing
// and the select-width helper.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned DEFAULT_N_CH  = 16;
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Channel-index width; a single channel bit is still kept for N_CH < 2.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping from the last channel back to channel 0.
module rr_arbiter #(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

    logic [SEL_W:0] idx;

    // One extra bit lets ptr + k exceed N_CH before the modulo fold.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx >= N_CH_W) begin
                idx = idx - N_CH_W;
            end
            if (!gnt_vld && req[idx[SEL_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin
// arbitration feeding a single registered output stage.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = DEFAULT_N_CH,
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W:0]   N_CH_W  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] cand_c;
    logic             cand_vld_c;
    logic             load_en_c;
    logic             xfer_c;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Candidate selection; an out-of-range fixed select simply yields nothing.
    always_comb begin
        cand_c     = '0;
        cand_vld_c = 1'b0;
        if (mode == MODE_RR) begin
            cand_c     = rr_idx;
            cand_vld_c = rr_vld;
        end else if ({1'b0, sel} < N_CH_W) begin
            cand_c     = sel;
            cand_vld_c = in_valid[sel];
        end
    end

    // rst_n gates the handshake so in_ready stays low throughout reset.
    assign load_en_c = !out_valid || out_ready;
    assign xfer_c    = rst_n && load_en_c && cand_vld_c;

    always_comb begin
        in_ready = '0;
        if (xfer_c) begin
            in_ready[cand_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer_c) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[cand_c];
            out_ch    <= cand_c;
            if (mode == MODE_RR) begin
                ptr <= (cand_c == LAST_CH) ? '0 : cand_c + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The module SHALL have parameter N_CH, default 16, giving the number of input channels (2..64).
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the data bits per channel.
REQ-003 The module SHALL have derived localparam SEL_W = max(1, clog2(N_CH)), giving the width of the select and channel id.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 The module SHALL have port clk  input  1  as the sole clock, with all state updating on its rising edge.
REQ-006 The module SHALL have port rst_n  input  1  as the asynchronous active-low reset.
REQ-007 The module SHALL have port mode  input  1  selecting the arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-008 The module SHALL have port sel  input  SEL_W  giving the channel index used in fixed mode.
REQ-009 The module SHALL have port in_data  input  N_CH*WIDTH  carrying channel i on bits [i*WIDTH +: WIDTH].
REQ-010 The module SHALL have port in_valid  input  N_CH  carrying the per-channel valid.
REQ-011 The module SHALL have port in_ready  output  N_CH  carrying the per-channel ready, at most one bit high at a time.
REQ-012 The module SHALL have port out_data  output  WIDTH  carrying the registered selected data.
REQ-013 The module SHALL have port out_ch  output  SEL_W  carrying the index of the channel held in out_data.
REQ-014 The module SHALL have port out_valid  output  1  indicating that the output register holds a beat.
REQ-015 The module SHALL have port out_ready  input  1  as the downstream accept signal.

Function
REQ-016 The module SHALL define load_en = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-017 In fixed mode, the candidate SHALL be sel when sel < N_CH and in_valid[sel] = 1; otherwise there is no candidate.
REQ-018 In round-robin mode, the candidate SHALL be the first i with in_valid[i] = 1, searching from ptr upward and wrapping from N_CH-1 to 0.
REQ-019 The block SHALL raise in_ready[cand] only when load_en = 1 and a candidate exists; all other in_ready bits SHALL be 0.
REQ-020 A transfer SHALL occur when in_valid[cand] && in_ready[cand]; on that rising edge, out_data <= in_data[cand], out_ch <= cand, and out_valid <= 1.
REQ-021 When out_valid && out_ready and no transfer occurs, out_valid SHALL be cleared to 0 on the next edge.
REQ-022 The input-to-output latency SHALL be exactly 1 cycle, with sustained throughput of 1 beat per cycle when out_ready = 1.
REQ-023 When out_valid = 1 and out_ready = 0, out_data and out_ch SHALL hold stable and all in_ready bits SHALL be 0.
REQ-024 On each round-robin transfer, ptr SHALL advance to (cand + 1) mod N_CH, wrapping from N_CH-1 to 0.
REQ-025 Fixed-mode transfers SHALL leave ptr unchanged.
REQ-026 A change of mode or sel SHALL take effect in the same cycle's candidate selection, without flushing the output register.
REQ-027 In fixed mode, sel >= N_CH (non-power-of-2 N_CH) SHALL produce no transfer and no error; out_valid drains normally.
REQ-028 No input beat SHALL be dropped or duplicated: every in_valid && in_ready handshake SHALL appear exactly once on the output.

Reset
REQ-029 While rst_n = 0, the block SHALL force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, and all in_ready = 0, asynchronously.
REQ-030 Reset asserted mid-stream SHALL discard the held beat; after deassertion, the first arbitration SHALL start from channel 0.

Structure
REQ-031 Package stream_mux_pkg SHALL hold the mode encoding (MODE_FIXED = 0, MODE_RR = 1) and the default N_CH/WIDTH constants.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_arbiter (inputs: req[N_CH], ptr; outputs: gnt_idx, gnt_vld), instantiated once.
REQ-033 The block SHALL contain a single output register stage with no additional buffering.

Verification
REQ-034 The bench SHALL cover: N_CH = 16, WIDTH = 8, fixed mode, sel = 5, in_valid = 16'h0020, data 8'hA5, out_ready = 1 -> next cycle out_valid = 1, out_data = 8'hA5, out_ch = 5.
REQ-035 The bench SHALL cover: round-robin mode, all 16 valid, out_ready = 1 for 17 cycles -> out_ch sequence 0,1,...,15,0, one beat per cycle.
REQ-036 The bench SHALL cover: round-robin mode, in_valid = 16'h8001, ptr = 15 -> grant 15, then 0, then 15 (wrap).
REQ-037 The bench SHALL cover: out_ready = 0 for 4 cycles with a beat held -> out_data/out_ch unchanged and in_ready = 0; on out_ready = 1, exactly one beat leaves.
REQ-038 The bench SHALL cover: N_CH = 12, fixed mode, sel = 13 with all valid -> no in_ready and out_valid remains 0.
REQ-039 The bench SHALL cover: rst_n pulled low with out_valid = 1 and ptr = 7 -> outputs clear immediately; after release, first round-robin grant = lowest valid index from 0.
